// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and baud divisor helper.
// Used by both uart_tx and uart_rx.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_e;

   // Clock cycles per line bit; truncating division.
   function automatic int unsigned baud_div(input int unsigned clk_freq,
                                            input int unsigned baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and a combinational head read.
// Writes while full are dropped, even when a read happens in the same cycle.
module sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [DATA_WIDTH-1:0] din,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  full,
   output logic                  empty
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [AW:0]           count_q, count_d;
   logic                  wr_ok, rd_ok;

   assign wr_ok = wr_en && !full;
   assign rd_ok = rd_en && !empty;
   assign dout  = mem[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
      end else begin
         if (wr_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         full    <= (count_d == DEPTH_C);
         empty   <= (count_d == '0);
      end
   end

   // Storage carries no reset; validity is tracked by the pointers.
   always_ff @(posedge clk_i) begin
      if (wr_ok) mem[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/uart_tx.sv
// Buffered UART transmitter: FIFO-fed 8N1-style serialiser, LSB first, no parity.
// Frames run back-to-back without an idle gap while enabled and data is queued.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  tx_en_i,
   input  logic                  tx_we_i,
   input  logic [DATA_WIDTH-1:0] din_i,
   output logic                  tx_bit_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic                  busy_o
);

   localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);
   localparam int BCW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int BTW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);
   localparam logic [BTW-1:0] BIT_LAST  = BTW'(DATA_WIDTH - 1);

   tx_state_e             state_q, state_d;
   logic [BCW-1:0]        baud_cnt_q, baud_cnt_d;
   logic [BTW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  tx_bit_q, tx_bit_d;
   logic                  pop, baud_done;
   logic [DATA_WIDTH-1:0] fifo_dout;

   sync_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .wr_en  (tx_we_i),
      .rd_en  (pop),
      .din    (din_i),
      .dout   (fifo_dout),
      .full   (full_o),
      .empty  (empty_o)
   );

   assign baud_done = (baud_cnt_q == BAUD_LAST);
   assign busy_o    = (state_q != IDLE);
   assign tx_bit_o  = tx_bit_q;

   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      pop        = 1'b0;
      tx_bit_d   = 1'b1;

      if (state_q != IDLE) baud_cnt_d = baud_done ? '0 : baud_cnt_q + 1'b1;

      case (state_q)
         IDLE: begin
            if (tx_en_i && !empty_o) begin
               pop        = 1'b1;
               shift_d    = fifo_dout;
               baud_cnt_d = '0;
               state_d    = START;
            end
         end
         START: begin
            if (baud_done) begin
               bit_cnt_d = '0;
               state_d   = DATA;
            end
         end
         DATA: begin
            if (baud_done) begin
               shift_d = shift_q >> 1;
               if (bit_cnt_q == BIT_LAST) state_d = STOP;
               else                       bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         STOP: begin
            // Chain straight into the next start bit when more data is waiting.
            if (baud_done) begin
               if (tx_en_i && !empty_o) begin
                  pop     = 1'b1;
                  shift_d = fifo_dout;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Line level is registered from the next state so it changes with the FSM.
      case (state_d)
         START:   tx_bit_d = 1'b0;
         DATA:    tx_bit_d = shift_d[0];
         default: tx_bit_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         baud_cnt_q <= '0;
         bit_cnt_q  <= '0;
         tx_bit_q   <= 1'b1;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         tx_bit_q   <= tx_bit_d;
      end
   end

   always_ff @(posedge clk_i) begin
      shift_q <= shift_d;
   end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-timeline model, serial line decoder and directed scenarios.
// Runs with a small baud divisor (1 MHz / 115200 -> 8 cycles per bit) to keep frames short.
module tb_uart_tx;

   localparam int CLK_FREQ  = 1_000_000;
   localparam int BAUD_RATE = 115_200;
   localparam int DW        = 8;
   localparam int DEPTH     = 16;
   localparam int B         = 8;            // 1_000_000 / 115_200 truncated
   localparam int FRAME     = (DW + 2) * B;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          tx_en = 1'b0;
   logic          tx_we = 1'b0;
   logic [DW-1:0] din = '0;
   logic          tx_bit, full, empty, busy;
   bit            chk_en = 1'b0;

   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   uart_tx #(
      .CLK_FREQ   (CLK_FREQ),
      .BAUD_RATE  (BAUD_RATE),
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .tx_en_i  (tx_en),
      .tx_we_i  (tx_we),
      .din_i    (din),
      .tx_bit_o (tx_bit),
      .full_o   (full),
      .empty_o  (empty),
      .busy_o   (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Model: queue of pending bytes plus position inside the frame on the line.
   logic [DW-1:0] mq[$];
   logic [DW-1:0] cur = '0;
   bit            active = 1'b0;
   int            pos = 0;
   int            m_sz0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         active = 1'b0;
         pos    = 0;
      end else begin
         m_sz0 = mq.size();
         if (active && pos != FRAME - 1) pos++;
         else if (tx_en && m_sz0 > 0) begin
            cur    = mq.pop_front();
            active = 1'b1;
            pos    = 0;
         end else active = 1'b0;
         if (tx_we && m_sz0 < DEPTH) mq.push_back(din);
      end
   end

   function automatic logic exp_line();
      if (!active)               return 1'b1;
      if (pos < B)               return 1'b0;
      if (pos >= (DW + 1) * B)   return 1'b1;
      return cur[pos / B - 1];
   endfunction

   always @(negedge clk) begin
      if (chk_en)
         check("line/busy/full/empty", {28'd0, tx_bit, busy, full, empty},
               {28'd0, exp_line(), active, (mq.size() == DEPTH), (mq.size() == 0)});
   end

   // Line decoder: samples each bit in its middle, as a receiver would.
   logic [DW-1:0] rx_q[$];
   logic [DW-1:0] rx_sh = '0;
   bit            rx_act = 1'b0;
   int            rx_cnt = 0;

   always @(negedge clk) begin
      if (!rst_n) rx_act = 1'b0;
      else if (!rx_act) begin
         if (tx_bit === 1'b0) begin
            rx_act = 1'b1;
            rx_cnt = 0;
         end
      end else begin
         rx_cnt++;
         if (rx_cnt == B / 2 + (DW + 1) * B) begin
            rx_q.push_back(rx_sh);
            rx_act = 1'b0;
         end else if (rx_cnt >= B / 2 + B && (rx_cnt - B / 2) % B == 0)
            rx_sh = {tx_bit, rx_sh[DW-1:1]};
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [DW-1:0] d);
      tx_we = 1'b1;
      din   = d;
      @(posedge clk);
      #1;
      tx_we = 1'b0;
   endtask

   task automatic wait_idle(input int max);
      int n = 0;
      while (!(empty && !busy) && n < max) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("wait_idle within bound", 32'(n < max), 32'd1);
   endtask

   logic            line_s [FRAME];
   logic [0:9]      seq;
   int              low, n;
   logic [DW-1:0]   loop_exp [4] = '{8'h01, 8'h09, 8'h00, 8'h07};

   initial begin
      cyc(3);
      check("reset tx_bit", tx_bit, 1);
      check("reset empty", empty, 1);
      check("reset full", full, 0);
      check("reset busy", busy, 0);
      rst_n  = 1'b1;
      chk_en = 1'b1;
      cyc(2);

      // Single byte 'h25: first-edge latency, bit pattern and bit duration.
      tx_en = 1'b1;
      wr(8'h25);
      check("E0 empty", empty, 0);
      check("E0 tx_bit", tx_bit, 1);
      check("E0 busy", busy, 0);
      cyc(1);
      check("E1 tx_bit", tx_bit, 0);
      check("E1 busy", busy, 1);
      check("E1 empty", empty, 1);
      for (int i = 0; i < FRAME; i++) begin
         line_s[i] = tx_bit;
         cyc(1);
      end
      low = 0;
      while (low < FRAME && line_s[low] == 1'b0) low++;
      check("start bit length", low, B);
      for (int k = 0; k < 10; k++) seq[k] = line_s[k * B + B / 2];
      check("h25 line bits", {22'd0, seq}, {22'd0, 10'b0101001001});
      check("after h25 busy", busy, 0);
      check("after h25 tx_bit", tx_bit, 1);

      // Loopback of four bytes.
      rx_q.delete();
      wr(8'h01); wr(8'h09); wr(8'h00); wr(8'h07);
      wait_idle(8 * FRAME);
      check("loopback count", rx_q.size(), 4);
      for (int i = 0; i < 4 && i < rx_q.size(); i++)
         check("loopback byte", rx_q[i], loop_exp[i]);

      // Fill while disabled; 17th write dropped, then a write rejected while full during the pop.
      tx_en = 1'b0;
      rx_q.delete();
      for (int i = 0; i <= DEPTH; i++) begin
         tx_we = 1'b1;
         din   = DW'(i);
         if (i == DEPTH - 1) check("full before 16th write", full, 0);
         if (i == DEPTH)     check("full after 16th write", full, 1);
         @(posedge clk);
         #1;
      end
      tx_we = 1'b0;
      check("full holds after drop", full, 1);
      check("busy while disabled", busy, 0);
      tx_en = 1'b1;
      wr(8'h55);
      check("write while full at pop rejected", full, 0);
      n = 0;
      while (busy && n < 20 * FRAME) begin
         cyc(1);
         n++;
      end
      check("busy run length", n, DEPTH * FRAME);
      check("drained empty", empty, 1);
      check("drained busy", busy, 0);
      check("burst count", rx_q.size(), DEPTH);
      for (int i = 0; i < DEPTH && i < rx_q.size(); i++)
         check("burst byte", rx_q[i], i);

      // Enable dropped mid-frame: current frame completes, queued byte waits.
      rx_q.delete();
      wr(8'hA5);
      wr(8'h3C);
      cyc(3 * B);
      tx_en = 1'b0;
      cyc(FRAME);
      check("paused busy", busy, 0);
      check("paused tx_bit", tx_bit, 1);
      check("paused empty", empty, 0);
      check("paused rx count", rx_q.size(), 1);
      if (rx_q.size() > 0) check("paused rx byte", rx_q[0], 8'hA5);
      cyc(2 * FRAME);
      check("still paused rx count", rx_q.size(), 1);
      tx_en = 1'b1;
      wait_idle(3 * FRAME);
      check("resumed rx count", rx_q.size(), 2);
      if (rx_q.size() > 1) check("resumed rx byte", rx_q[1], 8'h3C);

      // Reset mid-frame with three bytes still queued.
      tx_en = 1'b0;
      rx_q.delete();
      wr(8'h11); wr(8'h22); wr(8'h33); wr(8'h44);
      tx_en = 1'b1;
      cyc(2 * B + 3);
      check("pre-reset busy", busy, 1);
      check("pre-reset empty", empty, 0);
      rst_n = 1'b0;
      #1;
      check("reset mid-frame tx_bit", tx_bit, 1);
      check("reset mid-frame empty", empty, 1);
      check("reset mid-frame busy", busy, 0);
      cyc(1);
      rst_n = 1'b1;
      cyc(2 * FRAME);
      check("post-reset busy", busy, 0);
      check("post-reset frames", rx_q.size(), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
